// File: rtl/axi_wr_slave_if.sv
// AXI write-channel bundle plus the write-request side toward the DDR2 command core.
// No latency of its own: wires only.
// Backpressure is carried by the awready/wready/bready handshakes and the wr_req/wr_ack pair.
interface axi_wr_slave_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  // AXI write address channel
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  // AXI write data channel
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  // AXI write response channel
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  // DDR2 command core side
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_len;
  logic                  wr_data_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;

  modport slave (
    input  awvalid, awaddr, awlen,
    input  wvalid, wdata, wlast,
    input  bready,
    input  wr_data_en, wr_ack,
    output awready, wready, bvalid, bresp,
    output wr_req, wr_addr, wr_len, wr_data
  );

  modport master (
    output awvalid, awaddr, awlen,
    output wvalid, wdata, wlast,
    output bready,
    output wr_data_en, wr_ack,
    input  awready, wready, bvalid, bresp,
    input  wr_req, wr_addr, wr_len, wr_data
  );
endinterface

// File: rtl/axi_wr_slave.sv
// AXI write responder: buffers one AW burst's W beats, issues one DDR2 write request, returns B.
// Latency: wr_req the cycle after the final beat; bvalid the cycle after wr_ack; awready one bubble after B.
// Backpressure: single outstanding burst; awready/wready only in their phase, bvalid held until bready.
module axi_wr_slave #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  axi_wr_slave_if.slave  bus
);

  localparam int         PW      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [7:0] LEN_MAX = 8'(MAX_BEATS - 1);
  localparam logic [8:0] DEPTH   = 9'(MAX_BEATS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_CMD   = 2'd2,
    S_BRESP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            awlen_q, awlen_d;     // raw awlen, decides the final beat
  logic [7:0]            len_q, len_d;         // clamped length handed to the core
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [8:0]            pop_cnt_q, pop_cnt_d; // pops taken so far, caps at len+1
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] buf_mem [MAX_BEATS];
  logic                  buf_we;
  logic [PW-1:0]         buf_waddr;

  logic                  aw_rdy;
  logic                  w_rdy;
  logic                  b_vld;
  logic [1:0]            b_resp;
  logic                  req;
  logic                  is_final;

  assign is_final  = (beat_cnt_q == awlen_q);
  assign buf_waddr = beat_cnt_q[PW-1:0];

  // Next-state and handshake outputs for the burst sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    awlen_d    = awlen_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    pop_cnt_d  = pop_cnt_q;
    err_d      = err_q;
    buf_we     = 1'b0;
    aw_rdy     = 1'b0;
    w_rdy      = 1'b0;
    b_vld      = 1'b0;
    b_resp     = 2'b00;
    req        = 1'b0;

    case (state_q)
      S_IDLE: begin
        aw_rdy = 1'b1;
        if (bus.awvalid) begin
          addr_d     = bus.awaddr;
          awlen_d    = bus.awlen;
          // Oversized bursts are still fully accepted, but only MAX_BEATS reach the core.
          len_d      = (bus.awlen > LEN_MAX) ? LEN_MAX : bus.awlen;
          err_d      = (bus.awlen > LEN_MAX);
          beat_cnt_d = 8'd0;
          state_d    = S_WDATA;
        end
      end

      S_WDATA: begin
        w_rdy = 1'b1;
        if (bus.wvalid) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if ({1'b0, beat_cnt_q} < DEPTH) begin
            buf_we = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          // The beat count, not wlast, closes the burst; a disagreeing wlast only flags an error.
          if (bus.wlast != is_final) begin
            err_d = 1'b1;
          end
          if (is_final) begin
            state_d = S_CMD;
          end
        end
      end

      S_CMD: begin
        req = 1'b1;
        if (bus.wr_ack) begin
          rd_ptr_d  = '0;
          pop_cnt_d = 9'd0;
          state_d   = S_BRESP;
        end else if (bus.wr_data_en && (pop_cnt_q <= {1'b0, len_q})) begin
          rd_ptr_d  = rd_ptr_q + PW'(1);
          pop_cnt_d = pop_cnt_q + 9'd1;
        end
      end

      S_BRESP: begin
        b_vld  = 1'b1;
        b_resp = err_q ? 2'b10 : 2'b00;
        if (bus.bready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst bookkeeping: latched command, counters, pointers and sticky error.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q     <= '0;
      awlen_q    <= 8'd0;
      len_q      <= 8'd0;
      beat_cnt_q <= 8'd0;
      rd_ptr_q   <= '0;
      pop_cnt_q  <= 9'd0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      awlen_q    <= awlen_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      pop_cnt_q  <= pop_cnt_d;
      err_q      <= err_d;
    end
  end

  // Beat buffer; contents need no reset since nothing reads an unwritten slot in a clean burst.
  always_ff @(posedge clk_i) begin
    if (buf_we) begin
      buf_mem[buf_waddr] <= bus.wdata;
    end
  end

  assign bus.awready = aw_rdy;
  assign bus.wready  = w_rdy;
  assign bus.bvalid  = b_vld;
  assign bus.bresp   = b_resp;
  assign bus.wr_req  = req;
  assign bus.wr_addr = addr_q;
  assign bus.wr_len  = len_q;
  assign bus.wr_data = buf_mem[rd_ptr_q];

endmodule

// File: tb/tb_axi_wr_slave.sv
// Bench for axi_wr_slave: directed bursts, per-cycle comparison against a burst-level model,
// plus literal expectations on addresses, lengths, popped data and responses.
`timescale 1ns/1ps
module tb_axi_wr_slave;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int MB = 16;

  localparam int P_IDLE = 0;
  localparam int P_DATA = 1;
  localparam int P_CMD  = 2;
  localparam int P_RESP = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_wr_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_wr_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- burst-level model ----------------
  int          m_ph   = P_IDLE;
  logic [AW-1:0] m_addr = '0;
  int          m_alen = 0;
  int          m_len  = 0;
  int          m_cnt  = 0;
  int          m_pops = 0;
  bit          m_err  = 1'b0;
  logic [DW-1:0] m_mem [MB];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ph = P_IDLE; m_addr = '0; m_alen = 0; m_len = 0;
      m_cnt = 0; m_pops = 0; m_err = 1'b0;
    end else begin
      case (m_ph)
        P_IDLE: if (bus.awvalid) begin
          m_addr = bus.awaddr;
          m_alen = int'(bus.awlen);
          m_len  = (m_alen > MB - 1) ? MB - 1 : m_alen;
          m_err  = (m_alen > MB - 1);
          m_cnt  = 0;
          m_ph   = P_DATA;
        end
        P_DATA: if (bus.wvalid) begin
          bit fin;
          fin = (m_cnt == m_alen);
          if (m_cnt < MB) m_mem[m_cnt] = bus.wdata;
          else m_err = 1'b1;
          if (bus.wlast != fin) m_err = 1'b1;
          m_cnt++;
          if (fin) m_ph = P_CMD;
        end
        P_CMD: begin
          if (bus.wr_ack) begin
            m_ph = P_RESP; m_pops = 0;
          end else if (bus.wr_data_en && m_pops <= m_len) begin
            m_pops++;
          end
        end
        default: if (bus.bready) m_ph = P_IDLE;
      endcase
    end
  end

  // Every cycle: DUT outputs against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("awready", 64'(bus.awready), 64'(m_ph == P_IDLE));
    chk("wready",  64'(bus.wready),  64'(m_ph == P_DATA));
    chk("wr_req",  64'(bus.wr_req),  64'(m_ph == P_CMD));
    chk("bvalid",  64'(bus.bvalid),  64'(m_ph == P_RESP));
    chk("bresp",   64'(bus.bresp),   (m_ph == P_RESP && m_err) ? 64'd2 : 64'd0);
    chk("wr_addr", 64'(bus.wr_addr), 64'(m_addr));
    chk("wr_len",  64'(bus.wr_len),  64'(m_len));
    if (m_ph == P_CMD && m_pops <= m_len)
      chk("wr_data", 64'(bus.wr_data), 64'(m_mem[m_pops % MB]));
  end

  // ---------------- drivers ----------------
  logic [DW-1:0] popped [32];
  logic [1:0]    got_resp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [AW-1:0] a, input logic [7:0] l);
    int t = 0;
    bus.awvalid = 1'b1; bus.awaddr = a; bus.awlen = l;
    while (!bus.awready && t < 50) begin tick(); t++; end
    chk("aw_wait", 64'(t < 50), 64'd1);
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic do_w(input int n, input logic [DW-1:0] base, input int last_at, input bit gap);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bus.wvalid = 1'b1; bus.wdata = base + DW'(i); bus.wlast = (i == last_at);
      while (!bus.wready && t < 50) begin tick(); t++; end
      chk("w_wait", 64'(t < 50), 64'd1);
      tick();
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      if (i < n - 1) chk("wr_req_early", 64'(bus.wr_req), 64'd0);
      if (gap) tick();
    end
  endtask

  task automatic do_cmd(input int npops);
    int t = 0;
    while (!bus.wr_req && t < 50) begin tick(); t++; end
    chk("wr_req_delay", 64'(t), 64'd0);
    for (int i = 0; i < npops; i++) begin
      bus.wr_data_en = 1'b1;
      popped[i] = bus.wr_data;
      tick();
    end
    bus.wr_data_en = 1'b0;
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
  endtask

  task automatic do_b(input int hold);
    int t = 0;
    while (!bus.bvalid && t < 50) begin tick(); t++; end
    chk("b_wait", 64'(t < 50), 64'd1);
    got_resp = bus.bresp;
    for (int i = 0; i < hold; i++) begin
      chk("b_hold_vld",  64'(bus.bvalid),  64'd1);
      chk("b_hold_resp", 64'(bus.bresp),   64'(got_resp));
      chk("b_hold_awr",  64'(bus.awready), 64'd0);
      tick();
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("b_drop", 64'(bus.bvalid), 64'd0);
    chk("aw_back", 64'(bus.awready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awvalid = 0; bus.awaddr = '0; bus.awlen = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wlast = 0;
    bus.bready = 0; bus.wr_data_en = 0; bus.wr_ack = 0;
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    chk("rst_awready", 64'(bus.awready), 64'd1);
    chk("rst_wready",  64'(bus.wready),  64'd0);
    chk("rst_wr_req",  64'(bus.wr_req),  64'd0);

    // T1: 8 beats, popped every cycle
    do_aw(26'h10, 8'd7);
    do_w(8, 32'h0, 7, 1'b0);
    do_cmd(8);
    chk("t1_addr", 64'(bus.wr_addr), 64'h10);
    chk("t1_len",  64'(bus.wr_len),  64'd7);
    for (int i = 0; i < 8; i++) chk("t1_pop", 64'(popped[i]), 64'(i));
    do_b(0);
    chk("t1_resp", 64'(got_resp), 64'd0);

    // T2: single beat
    do_aw(26'h2000, 8'd0);
    do_w(1, 32'hA5A5_A5A5, 0, 1'b0);
    do_cmd(1);
    chk("t2_pop", 64'(popped[0]), 64'hA5A5_A5A5);
    do_b(0);
    chk("t2_resp", 64'(got_resp), 64'd0);

    // T3: wvalid toggling
    do_aw(26'h3_0000, 8'd3);
    do_w(4, 32'h3000_0000, 3, 1'b1);
    do_cmd(4);
    for (int i = 0; i < 4; i++) chk("t3_pop", 64'(popped[i]), 64'h3000_0000 + 64'(i));
    do_b(0);
    chk("t3_resp", 64'(got_resp), 64'd0);

    // T4: early wlast
    do_aw(26'h40, 8'd3);
    do_w(4, 32'h4000_0000, 1, 1'b0);
    do_cmd(4);
    chk("t4_pop3", 64'(popped[3]), 64'h4000_0003);
    do_b(0);
    chk("t4_resp", 64'(got_resp), 64'd2);

    // T5: oversized burst, extra pops ignored
    do_aw(26'h500, 8'd20);
    do_w(21, 32'h100, 20, 1'b0);
    chk("t5_len", 64'(bus.wr_len), 64'd15);
    do_cmd(18);
    for (int i = 0; i < 16; i++) chk("t5_pop", 64'(popped[i]), 64'h100 + 64'(i));
    do_b(0);
    chk("t5_resp", 64'(got_resp), 64'd2);

    // T6: bready stall, then reset in the middle of the next burst
    do_aw(26'h600, 8'd1);
    do_w(2, 32'h6000_0000, 1, 1'b0);
    do_cmd(2);
    do_b(5);
    chk("t6_resp", 64'(got_resp), 64'd0);
    do_aw(26'h700, 8'd7);
    do_w(3, 32'h7000_0000, 7, 1'b0);
    rstn = 1'b0;
    #1;
    chk("t6_rst_awready", 64'(bus.awready), 64'd1);
    chk("t6_rst_wready",  64'(bus.wready),  64'd0);
    chk("t6_rst_bvalid",  64'(bus.bvalid),  64'd0);
    chk("t6_rst_bresp",   64'(bus.bresp),   64'd0);
    chk("t6_rst_wr_req",  64'(bus.wr_req),  64'd0);
    chk("t6_rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("t6_rst_wr_len",  64'(bus.wr_len),  64'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("t6_post_awready", 64'(bus.awready), 64'd1);
    chk("t6_post_wr_req",  64'(bus.wr_req),  64'd0);

    // Recovery burst after reset
    do_aw(26'h800, 8'd1);
    do_w(2, 32'h8000_0000, 1, 1'b0);
    do_cmd(2);
    chk("t7_pop1", 64'(popped[1]), 64'h8000_0001);
    do_b(0);
    chk("t7_resp", 64'(got_resp), 64'd0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
